// File: rtl/banner_pkg.sv
// Shared constants and FSM encoding for the banner ROM readers.
package banner_pkg;

    localparam int BANNER_DEPTH  = 129;
    localparam int BANNER_WIDTH  = 57;
    localparam int BANNER_ADDR_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        FETCH,
        SEND,
        DONE
    } state_t;

endpackage

// File: rtl/banner_addr_wrap.sv
// Combinational modulo-DEPTH adder: address = (offset + col) mod DEPTH,
// valid for offset, col both in 0..DEPTH-1.
module banner_addr_wrap
    import banner_pkg::*;
#(
    parameter int DEPTH = BANNER_DEPTH
) (
    input  logic [BANNER_ADDR_W-1:0] offset,
    input  logic [BANNER_ADDR_W-1:0] col,
    output logic [BANNER_ADDR_W-1:0] address
);

    localparam logic [BANNER_ADDR_W:0] LIMIT = (BANNER_ADDR_W + 1)'(DEPTH);

    logic [BANNER_ADDR_W:0] sum;

    // One conditional subtract folds the 9-bit sum back into 0..DEPTH-1.
    always_comb begin
        sum     = {1'b0, offset} + {1'b0, col};
        address = (sum >= LIMIT) ? BANNER_ADDR_W'(sum - LIMIT) : BANNER_ADDR_W'(sum);
    end

endmodule

// File: rtl/banner_column_reader.sv
// Walks a WINDOW-row viewport of the banner ROM, hands each row to the
// LED driver over valid/ready, and scrolls the viewport every SCROLL_FRAMES.
module banner_column_reader
    import banner_pkg::*;
#(
    parameter int DEPTH         = BANNER_DEPTH,
    parameter int WIDTH         = BANNER_WIDTH,
    parameter int WINDOW        = 16,
    parameter int SCROLL_FRAMES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [7:0]       rom_address,
    input  logic [WIDTH-1:0] rom_data,
    output logic [WIDTH-1:0] col_data,
    output logic [7:0]       col_index,
    output logic             col_valid,
    input  logic             col_ready,
    output logic             busy,
    output logic             frame_done,
    output logic [7:0]       offset
);

    localparam int         FC_W        = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam logic [7:0] LAST_COL    = 8'(WINDOW - 1);
    localparam logic [7:0] LAST_OFFSET = 8'(DEPTH - 1);
    localparam logic [FC_W-1:0] LAST_FRAME = FC_W'(SCROLL_FRAMES - 1);

    state_t          state;
    state_t          state_next;
    logic [7:0]      col;
    logic [7:0]      addr_col;
    logic [7:0]      next_addr;
    logic [FC_W-1:0] frame_cnt;
    logic            handshake;

    assign handshake = col_valid && col_ready;

    // One shared wrap adder: column 0 when launching a frame, col+1 otherwise.
    always_comb begin
        addr_col = (state == IDLE) ? '0 : col + 8'd1;
    end

    banner_addr_wrap #(
        .DEPTH(DEPTH)
    ) u_addr_wrap (
        .offset (offset),
        .col    (addr_col),
        .address(next_addr)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ADDR;
            ADDR:    state_next = FETCH;
            FETCH:   state_next = SEND;
            SEND:    if (handshake) state_next = (col == LAST_COL) ? DONE : ADDR;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy       = (state != IDLE);
        frame_done = (state == DONE);
    end

    // Datapath: address, column capture, frame counter and scroll offset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_address <= '0;
            col_data    <= '0;
            col_index   <= '0;
            col_valid   <= 1'b0;
            col         <= '0;
            frame_cnt   <= '0;
            offset      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        col         <= '0;
                        rom_address <= next_addr;
                    end
                end
                FETCH: begin
                    col_data  <= rom_data;
                    col_index <= col;
                    col_valid <= 1'b1;
                end
                SEND: begin
                    if (handshake) begin
                        col_valid <= 1'b0;
                        if (col != LAST_COL) begin
                            col         <= col + 8'd1;
                            rom_address <= next_addr;
                        end
                    end
                end
                DONE: begin
                    if (frame_cnt == LAST_FRAME) begin
                        frame_cnt <= '0;
                        offset    <= (offset == LAST_OFFSET) ? '0 : offset + 8'd1;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_banner_column_reader.sv
// Scoreboard bench for banner_column_reader with a registered-address ROM model.
module tb_banner_column_reader;

    localparam int DEPTH  = 129;
    localparam int WIDTH  = 57;
    localparam int WINDOW = 16;
    localparam int SCROLL = 4;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [7:0]       idx;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       rom_address;
    logic [WIDTH-1:0] rom_data;
    logic [WIDTH-1:0] col_data;
    logic [7:0]       col_index;
    logic             col_valid;
    logic             col_ready = 1'b0;
    logic             busy;
    logic             frame_done;
    logic [7:0]       offset;

    logic [7:0]       rom_q = '0;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;
    int   m_offset = 0;
    int   m_frames = 0;

    always #5 clk = ~clk;

    banner_column_reader #(
        .DEPTH        (DEPTH),
        .WIDTH        (WIDTH),
        .WINDOW       (WINDOW),
        .SCROLL_FRAMES(SCROLL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rom_address(rom_address),
        .rom_data   (rom_data),
        .col_data   (col_data),
        .col_index  (col_index),
        .col_valid  (col_valid),
        .col_ready  (col_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .offset     (offset)
    );

    // ROM model: address registered, data = address one cycle later.
    always @(posedge clk) rom_q <= rom_address;
    assign rom_data = {49'b0, rom_q};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard pops on handshake, address range, scroll model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) chk("addr_range", (rom_address < 8'(DEPTH)), 1);
            if (col_valid && col_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_extra_column", col_index, 8'hff);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("col_data", col_data, e.data);
                    chk("col_index", col_index, e.idx);
                end
            end
            if (frame_done) begin
                done_count++;
                chk("offset_in_done", offset, m_offset);
                m_frames++;
                if (m_frames == SCROLL) begin
                    m_frames = 0;
                    m_offset = (m_offset + 1) % DEPTH;
                end
            end
        end
    end

    task automatic run_frame(input int hold_col, input int hold_len, input int poke_col,
                             input bit poke_done, output int t_first, output int t_done,
                             output int t_gap);
        int   edges;
        int   hs_edge;
        int   held;
        int   dc0;
        bit   hs_pending;
        bit   poked;
        logic [WIDTH-1:0] hold_data;
        logic [7:0]       hold_addr;
        dc0 = done_count;
        t_first = -1; t_done = -1; t_gap = -1; hs_edge = -1;
        held = 0; hs_pending = 0; poked = 0;
        hold_data = '0; hold_addr = '0;
        for (int c = 0; c < WINDOW; c++)
            sb.push_back('{data: WIDTH'((m_offset + c) % DEPTH), idx: 8'(c)});
        start = 1'b1;
        col_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        chk("addr_first", rom_address, m_offset);
        chk("busy_start", busy, 1);
        while (t_done < 0 && edges < 4000) begin
            start = 1'b0;
            col_ready = 1'b0;
            if (frame_done) begin
                t_done = edges;
                if (poke_done) start = 1'b1;
            end else if (col_valid) begin
                if (t_first < 0) t_first = edges;
                if (hs_edge >= 0 && t_gap < 0) t_gap = edges - hs_edge;
                if (col_index == 8'(poke_col) && !poked) begin
                    start = 1'b1;
                    poked = 1'b1;
                end
                if (col_index == 8'(hold_col) && held < hold_len) begin
                    if (held == 0) begin
                        hold_data = col_data;
                        hold_addr = rom_address;
                    end else begin
                        chk("hold_data", col_data, hold_data);
                        chk("hold_addr", rom_address, hold_addr);
                    end
                    held++;
                end else begin
                    col_ready = 1'b1;
                    if (col_index == 8'(hold_col) && hold_len > 0) hs_pending = 1'b1;
                end
            end
            if (t_done < 0) begin
                @(posedge clk); #1;
                edges++;
                if (hs_pending) begin
                    hs_edge = edges;
                    hs_pending = 1'b0;
                end
            end
        end
        chk("frame_done_seen", (t_done >= 0), 1);
        @(posedge clk); #1;
        start = 1'b0;
        col_ready = 1'b0;
        chk("done_count", done_count - dc0, 1);
        chk("idle_busy", busy, 0);
        chk("sb_empty", sb.size(), 0);
        chk("offset_after", offset, m_offset);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rom_address"}, rom_address, 0);
        chk({tag, "_col_data"}, col_data, 0);
        chk({tag, "_col_index"}, col_index, 0);
        chk({tag, "_col_valid"}, col_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_offset"}, offset, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tf, td, tg, n, dc0;
        int exp_off[4];
        // Reset.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame with col_ready high: latency and frame length.
        run_frame(-1, 0, -1, 0, tf, td, tg);
        chk("first_valid_edge", tf, 3);
        chk("frame_done_edge", td, 3 * WINDOW + 1);

        // Backpressure on column 5.
        run_frame(5, 10, -1, 0, tf, td, tg);
        chk("gap_after_hold", tg, 2);

        // Start while busy (SEND of col 3) and during DONE: both dropped.
        run_frame(-1, 0, 3, 1, tf, td, tg);
        run_frame(-1, 0, -1, 0, tf, td, tg);

        // Scroll to offset 120 then run the wrapping frame.
        n = 0;
        while (m_offset != 120 && n < 600) begin
            run_frame(-1, 0, -1, 0, tf, td, tg);
            n++;
        end
        chk("reached_offset_120", offset, 120);
        run_frame(-1, 0, -1, 0, tf, td, tg);
        run_frame(-1, 0, -1, 0, tf, td, tg);
        run_frame(-1, 0, -1, 0, tf, td, tg);

        // Reset during FETCH of column 7.
        for (int c = 0; c < WINDOW; c++)
            sb.push_back('{data: WIDTH'((m_offset + c) % DEPTH), idx: 8'(c)});
        start = 1'b1;
        col_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(col_valid && col_index == 8'd6) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_col6", col_index, 6);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("in_fetch_busy", busy, 1);
        chk("in_fetch_valid", col_valid, 0);
        rst_n = 1'b0;
        col_ready = 1'b0;
        sb.delete();
        dc0 = done_count;
        @(posedge clk); #1;
        check_all_zero("midreset");
        m_offset = 0;
        m_frames = 0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midreset_no_done", done_count - dc0, 0);

        // Scroll cadence: offset advances only in the 4th frame's DONE.
        exp_off[0] = 0; exp_off[1] = 0; exp_off[2] = 0; exp_off[3] = 1;
        for (int f = 0; f < 4; f++) begin
            run_frame(-1, 0, -1, 0, tf, td, tg);
            chk("cadence_offset", offset, exp_off[f]);
        end
        run_frame(-1, 0, -1, 0, tf, td, tg);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
